// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: EX_MEM / MEM_WB field layout, MemToReg encodings,
// data-memory handshake FSM states and the write-back result selector.
package pipeline_pkg;

  localparam int unsigned EX_MEM_W = 140;
  localparam int unsigned MEM_WB_W = 39;

  // EX_MEM field offsets
  localparam int unsigned ExmStoreLsb  = 0;
  localparam int unsigned ExmAluLsb    = 32;
  localparam int unsigned ExmRegLsb    = 64;
  localparam int unsigned ExmMemRdBit  = 69;
  localparam int unsigned ExmMemWrBit  = 70;
  localparam int unsigned ExmRegWrBit  = 71;
  localparam int unsigned ExmMtrLsb    = 72;
  localparam int unsigned ExmPc4Lsb    = 74;
  localparam int unsigned ExmLuDataLsb = 106;
  localparam int unsigned ExmLuOpBit   = 138;
  localparam int unsigned ExmPcSrcBBit = 139;

  // MEM_WB field offsets
  localparam int unsigned MwbDataLsb = 0;
  localparam int unsigned MwbRegLsb  = 32;
  localparam int unsigned MwbRegWrBit = 37;
  localparam int unsigned MwbExcBit  = 38;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } hs_state_e;

  // LUOp overrides MemToReg; the unused 2'b11 code falls back to the ALU result.
  function automatic logic [31:0] pick_result(input logic        lu_op,
                                              input logic [1:0]  mtr,
                                              input logic [31:0] lu_data,
                                              input logic [31:0] pc_plus4,
                                              input logic [31:0] alu,
                                              input logic [31:0] mem);
    logic [31:0] r;
    r = alu;
    if (lu_op) begin
      r = lu_data;
    end else begin
      case (mtr)
        MTR_ALU: r = alu;
        MTR_MEM: r = mem;
        MTR_PC:  r = pc_plus4;
        default: r = alu;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// IDLE/WAIT handshake FSM for one data-memory access: request generation, stall,
// wait-cycle timeout and the sticky bus error flag.
module dmem_handshake
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic clk,
  input  logic reset_b,
  input  logic start_i,
  input  logic ready_i,
  output logic req_o,
  output logic stall_o,
  output logic abort_o,
  output logic bus_err_o
);

  hs_state_e            st_q, st_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    req_o     = 1'b0;
    abort_o   = 1'b0;
    unique case (st_q)
      StIdle: begin
        req_o = start_i;
        if (start_i && !ready_i) begin
          st_d  = StWait;
          cnt_d = '0;
        end
      end
      StWait: begin
        // Upstream is frozen, so the request stays asserted until ready or abort.
        req_o = 1'b1;
        if (ready_i) begin
          st_d = StIdle;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
          abort_o   = 1'b1;
          bus_err_d = 1'b1;
          st_d      = StIdle;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: st_d = StIdle;
    endcase
    // Release the pipeline in the completing cycle so the access is not re-issued.
    stall_o = req_o && !ready_i && !abort_o;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      st_q      <= StIdle;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks EX_MEM, runs the data-memory access and registers MEM_WB.
// Optional MEM_STAGE_MISALIGN_EXC_EN turns misaligned accesses into a MEM_WB exception.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [EX_MEM_W-1:0] EX_MEM,
  mem_stage_if.master         dmem,
  output logic                mem_stall,
  output logic                bus_err,
  output logic [4:0]          EX_MEM_Rd,
  output logic                EX_MEM_RegWrite,
  output logic [31:0]         EX_MEM_RdData,
  output logic [MEM_WB_W-1:0] MEM_WB
);

  logic [31:0] store_data, alu_res, pc_plus4, lu_data;
  logic [4:0]  write_reg;
  logic [1:0]  mem_to_reg;
  logic        mem_read, mem_write, reg_write, lu_op;
  logic        unused_pcsrcb;

  assign store_data    = EX_MEM[ExmStoreLsb +: 32];
  assign alu_res       = EX_MEM[ExmAluLsb +: 32];
  assign write_reg     = EX_MEM[ExmRegLsb +: 5];
  assign mem_read      = EX_MEM[ExmMemRdBit];
  assign mem_write     = EX_MEM[ExmMemWrBit];
  assign reg_write     = EX_MEM[ExmRegWrBit];
  assign mem_to_reg    = EX_MEM[ExmMtrLsb +: 2];
  assign pc_plus4      = EX_MEM[ExmPc4Lsb +: 32];
  assign lu_data       = EX_MEM[ExmLuDataLsb +: 32];
  assign lu_op         = EX_MEM[ExmLuOpBit];
  assign unused_pcsrcb = EX_MEM[ExmPcSrcBBit];

  logic acc, misalign, start;
  logic hs_req, hs_stall, hs_abort, hs_bus_err;

  assign acc = mem_read | mem_write;

`ifdef MEM_STAGE_MISALIGN_EXC_EN
  assign misalign = acc & (alu_res[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign start = acc & ~misalign;

  dmem_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_handshake (
    .clk       (clk),
    .reset_b   (reset_b),
    .start_i   (start),
    .ready_i   (dmem.dmem_ready),
    .req_o     (hs_req),
    .stall_o   (hs_stall),
    .abort_o   (hs_abort),
    .bus_err_o (hs_bus_err)
  );

  logic [31:0] fwd_data, wb_data;

  assign fwd_data = pick_result(lu_op, mem_to_reg, lu_data, pc_plus4, alu_res, alu_res);
  assign wb_data  = pick_result(lu_op, mem_to_reg, lu_data, pc_plus4, alu_res, dmem.dmem_rdata);

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
    mem_stall       = 1'b0;
    EX_MEM_Rd       = '0;
    EX_MEM_RegWrite = 1'b0;
    EX_MEM_RdData   = '0;
    if (reset_b) begin
      dmem.dmem_req   = hs_req;
      dmem.dmem_we    = mem_write;
      dmem.dmem_addr  = alu_res;
      dmem.dmem_wdata = store_data;
      mem_stall       = hs_stall;
      EX_MEM_Rd       = write_reg;
      EX_MEM_RegWrite = reg_write;
      EX_MEM_RdData   = fwd_data;
    end
  end

  logic [MEM_WB_W-1:0] mem_wb_q, mem_wb_d;

  // Held during stalls; aborted and misaligned accesses never write the register file.
  always_comb begin
    mem_wb_d = mem_wb_q;
    if (!hs_stall) begin
      mem_wb_d[MwbDataLsb +: 32] = (hs_abort || misalign) ? fwd_data : wb_data;
      mem_wb_d[MwbRegLsb +: 5]   = write_reg;
      mem_wb_d[MwbRegWrBit]      = reg_write & ~hs_abort & ~misalign;
      mem_wb_d[MwbExcBit]        = misalign;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign MEM_WB  = mem_wb_q;
  assign bus_err = hs_bus_err;

endmodule
